fork_join_engine: RTL and testbench
===================================

FORK_JOIN_ENGINE -- requirements
Module: fork_join_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of concurrent delay channels (2..16).
REQ-002 SHALL have parameter DLY_W, default 8, meaning delay-counter width in cycles.
REQ-003 SHALL have port clk  input  1  meaning single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port launch_en  input  1  meaning start the channel on launch_ch this cycle.
REQ-006 SHALL have port launch_ch  input  $clog2(NUM_CH)  meaning channel index to launch.
REQ-007 SHALL have port launch_dly  input  DLY_W  meaning delay D for the launched channel.
REQ-008 SHALL have port join_req  input  1  meaning arm the join FSM over the currently busy channels.
REQ-009 SHALL have port join_mode  input  2  meaning 0=ALL, 1=ANY, 2=NONE, 3=reserved (treated as NONE).
REQ-010 SHALL have port kill  input  1  meaning abort every running channel and the pending join.
REQ-011 SHALL have port busy  output  NUM_CH  meaning per-channel running flag.
REQ-012 SHALL have port done  output  NUM_CH  meaning one-cycle per-channel completion pulse.
REQ-013 SHALL have port join_done  output  1  meaning one-cycle pulse when the armed join condition is met.
REQ-014 SHALL have port killed  output  1  meaning one-cycle pulse acknowledging kill.
REQ-015 SHALL have port launch_err  output  1  meaning one-cycle pulse on an illegal launch.

Function
REQ-016 Each channel SHALL be IDLE or RUN, with a DLY_W down-counter; busy[i]=1 iff RUN.
REQ-017 A launch sampled at edge k SHALL load the counter with D, set busy after edge k, and pulse done[i] for exactly one cycle after edge k+D+1, with busy[i] falling on that same edge.
REQ-018 D=0 SHALL produce done one cycle after launch; D=2^DLY_W-1 SHALL be supported without wrap.
REQ-019 A launch to a busy channel, or with launch_ch>=NUM_CH, SHALL be ignored and pulse launch_err after that edge.
REQ-020 A launch to a channel whose done pulse occurs on the same edge SHALL be legal, and the channel SHALL re-enter RUN.
REQ-021 Multiple channels SHALL complete on the same edge independently; done SHALL carry all of their bits.
REQ-022 The join FSM SHALL have states IDLE and WAIT; join_req in IDLE SHALL capture mask = busy after the same edge, including any launch accepted that cycle.
REQ-023 In WAIT, each done[i] with mask[i]=1 SHALL clear mask[i].
REQ-024 In mode ALL, join_done SHALL assert on the same edge as the done pulse that clears the last mask bit, then return to IDLE.
REQ-025 In mode ANY, join_done SHALL assert with the first masked done pulse, return to IDLE, and leave other channels running.
REQ-026 In mode NONE, or with an empty captured mask, join_done SHALL pulse one cycle after join_req, and the FSM SHALL remain in IDLE.
REQ-027 join_req while in WAIT SHALL be ignored; join_mode SHALL be sampled only with an accepted join_req.
REQ-028 kill SHALL force every channel to IDLE, zero the counters, clear the mask, and put the FSM in IDLE on the next edge; killed SHALL pulse after that edge.
REQ-029 kill SHALL take priority over the same-cycle launch, join_req and completion: no done, join_done or launch_err SHALL be produced for that edge.

Reset
REQ-030 While rst=1 at an edge, busy, done, join_done, killed, launch_err, the counters and the mask SHALL be 0, the FSM SHALL be IDLE, and all inputs SHALL be ignored.
REQ-031 Reset mid-operation SHALL discard running channels silently, with no done or killed pulse.

Verification
REQ-032 Launch ch0 D=30, ch1 D=20, ch2 D=10 on consecutive edges 0,1,2, then join ALL -> done[2]@13, done[1]@22, done[0]@31, join_done@31.
REQ-033 Same launches with join ANY -> join_done@13 with done[2]; ch0 and ch1 still complete @22 and @31, with no further join_done.
REQ-034 Same launches with join NONE -> join_done one cycle after join_req; all three done pulses occur as in REQ-032.
REQ-035 Launch ch0 D=30 and ch1 D=5, join ALL, kill at edge 3 -> killed@4, busy=0, no done and no join_done through edge 40.
REQ-036 Launch ch3 D=0 -> done[3] next edge; relaunch ch3 while busy with D=4 -> launch_err, original timing kept.
REQ-037 Launch ch1 D=8, assert rst at edge 4 -> all outputs 0, and no done[1] at edge 9.

Source files
------------

// File: rtl/fork_join_engine.sv
// Fork/join engine: NUM_CH independent delay channels plus a join FSM that
// waits for ALL or ANY of the channels busy when it was armed.
module fork_join_engine #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DLY_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      launch_en,
  input  logic [$clog2(NUM_CH)-1:0] launch_ch,
  input  logic [DLY_W-1:0]          launch_dly,
  input  logic                      join_req,
  input  logic [1:0]                join_mode,
  input  logic                      kill,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic                      join_done,
  output logic                      killed,
  output logic                      launch_err
);

  typedef enum logic [0:0] {StIdle, StWait} join_st_e;

  join_st_e                       state_q;
  logic [NUM_CH-1:0]              busy_q, busy_d;
  logic [NUM_CH-1:0][DLY_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]              done_q, done_d;
  logic                           err_q, err_d;
  logic                           killed_q;
  logic                           join_done_q;
  logic [NUM_CH-1:0]              mask_q;
  logic                           any_q;
  logic                           launch_in_range;

  always_comb begin
    busy_d          = busy_q;
    cnt_d           = cnt_q;
    done_d          = '0;
    err_d           = 1'b0;
    launch_in_range = 32'(launch_ch) < NUM_CH;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (busy_q[i]) begin
        if (cnt_q[i] == '0) begin
          busy_d[i] = 1'b0;
          done_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - DLY_W'(1);
        end
      end
    end
    // A channel finishing on this edge may be relaunched immediately.
    if (launch_en) begin
      if (!launch_in_range || (busy_q[launch_ch] && cnt_q[launch_ch] != '0)) begin
        err_d = 1'b1;
      end else begin
        busy_d[launch_ch] = 1'b1;
        cnt_d[launch_ch]  = launch_dly;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_q      <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      killed_q    <= 1'b0;
      join_done_q <= 1'b0;
      mask_q      <= '0;
      any_q       <= 1'b0;
    end else if (kill) begin
      state_q     <= StIdle;
      busy_q      <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      killed_q    <= 1'b1;
      join_done_q <= 1'b0;
      mask_q      <= '0;
      any_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      killed_q    <= 1'b0;
      join_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (join_req) begin
            // NONE/reserved modes or nothing to wait for complete at once.
            if (!join_mode[1] && (busy_d != '0)) begin
              state_q <= StWait;
              mask_q  <= busy_d;
              any_q   <= join_mode[0];
            end else begin
              join_done_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (any_q ? ((mask_q & done_d) != '0) : ((mask_q & ~done_d) == '0)) begin
            join_done_q <= 1'b1;
            mask_q      <= '0;
            state_q     <= StIdle;
          end else begin
            mask_q <= mask_q & ~done_d;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign join_done  = join_done_q;
  assign killed     = killed_q;
  assign launch_err = err_q;

endmodule

// File: tb/tb_fork_join_engine.sv
// Directed bench for fork_join_engine; edge numbers count rising edges from
// the first launch of each scenario.
module tb_fork_join_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       launch_en;
  logic [1:0] launch_ch;
  logic [7:0] launch_dly;
  logic       join_req;
  logic [1:0] join_mode;
  logic       kill;
  logic [3:0] busy;
  logic [3:0] done;
  logic       join_done;
  logic       killed;
  logic       launch_err;

  int n_checks = 0;
  int n_errors = 0;

  fork_join_engine #(
    .NUM_CH(4),
    .DLY_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .launch_en (launch_en),
    .launch_ch (launch_ch),
    .launch_dly(launch_dly),
    .join_req  (join_req),
    .join_mode (join_mode),
    .kill      (kill),
    .busy      (busy),
    .done      (done),
    .join_done (join_done),
    .killed    (killed),
    .launch_err(launch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    launch_en  = 1'b0;
    launch_ch  = 2'd0;
    launch_dly = 8'd0;
    join_req   = 1'b0;
    join_mode  = 2'd0;
    kill       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_jd", 32'(join_done), 32'h0);
    check("rst_killed", 32'(killed), 32'h0);
    check("rst_err", 32'(launch_err), 32'h0);
  endtask

  // ch0 D=30, ch1 D=20, ch2 D=10 at edges 0..2, join at edge 3.
  task automatic fj_scenario(input logic [1:0] mode, input int jd_edge, input bit rejoin);
    logic [3:0] exp_done;
    do_reset();
    for (int e = 0; e <= 34; e++) begin
      clear_inputs();
      launch_en  = (e <= 2);
      launch_ch  = 2'(e);
      launch_dly = 8'(30 - 10 * e);
      join_req   = (e == 3) || (rejoin && e == 10);
      join_mode  = (e == 10) ? 2'd2 : mode;
      tick();
      exp_done = (e == 13) ? 4'b0100 : (e == 22) ? 4'b0010 : (e == 31) ? 4'b0001 : 4'b0000;
      check($sformatf("m%0d_done@%0d", mode, e), 32'(done), 32'(exp_done));
      check($sformatf("m%0d_jd@%0d", mode, e), 32'(join_done), 32'(e == jd_edge));
      if (e == 3) check($sformatf("m%0d_busy@3", mode), 32'(busy), 32'h7);
      if (e == 13) check($sformatf("m%0d_busy@13", mode), 32'(busy), 32'h3);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    fj_scenario(2'd0, 31, 1'b1);
    fj_scenario(2'd1, 13, 1'b1);
    fj_scenario(2'd2, 3, 1'b0);
    fj_scenario(2'd3, 3, 1'b0);

    // Kill after launches and an armed ALL join.
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      clear_inputs();
      launch_en  = (e <= 1);
      launch_ch  = 2'(e);
      launch_dly = (e == 0) ? 8'd30 : 8'd5;
      join_req   = (e == 2);
      kill       = (e == 4);
      tick();
      check($sformatf("kill_killed@%0d", e), 32'(killed), 32'(e == 4));
      check($sformatf("kill_done@%0d", e), 32'(done), 32'h0);
      check($sformatf("kill_jd@%0d", e), 32'(join_done), 32'h0);
      if (e == 3) check("kill_busy@3", 32'(busy), 32'h3);
      if (e >= 4) check($sformatf("kill_busy@%0d", e), 32'(busy), 32'h0);
    end

    // D=0, busy relaunch error, same-edge relaunch.
    do_reset();
    for (int e = 0; e <= 16; e++) begin
      clear_inputs();
      launch_en  = (e == 0) || (e == 2) || (e == 3) || (e == 10) || (e == 12);
      launch_ch  = (e >= 10) ? 2'd2 : 2'd3;
      launch_dly = (e == 2) ? 8'd6 : (e == 3) ? 8'd4 : (e == 10) ? 8'd1 : 8'd0;
      tick();
      check($sformatf("err_done@%0d", e), 32'(done),
            (e == 1 || e == 9) ? 32'h8 : (e == 12 || e == 13) ? 32'h4 : 32'h0);
      check($sformatf("err_err@%0d", e), 32'(launch_err), 32'(e == 3));
      if (e == 3) check("err_busy@3", 32'(busy), 32'h8);
      if (e == 12) check("err_busy@12", 32'(busy), 32'h4);
    end

    // Maximum delay, no wrap.
    do_reset();
    for (int e = 0; e <= 258; e++) begin
      clear_inputs();
      launch_en  = (e == 0);
      launch_dly = 8'd255;
      tick();
      check($sformatf("max_done@%0d", e), 32'(done), 32'(e == 256));
      if (e == 255 || e == 256) check($sformatf("max_busy@%0d", e), 32'(busy), 32'(e == 255));
    end

    // Reset mid-run discards the channel silently.
    do_reset();
    for (int e = 0; e <= 12; e++) begin
      clear_inputs();
      launch_en  = (e == 0);
      launch_ch  = 2'd1;
      launch_dly = 8'd8;
      rst        = (e == 4);
      tick();
      rst = 1'b0;
      check($sformatf("rstmid_busy@%0d", e), 32'(busy), (e < 4) ? 32'h2 : 32'h0);
      check($sformatf("rstmid_done@%0d", e), 32'(done), 32'h0);
      check($sformatf("rstmid_killed@%0d", e), 32'(killed), 32'h0);
      check($sformatf("rstmid_jd@%0d", e), 32'(join_done), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
